read_buffer: RTL and testbench

// - Read-side counterpart of write_buffer: Avalon-MM read master that fetches 24-bit pixels from SDRAM.
// - Pixels land in a ping-pong pair of DEPTH-entry banks and are streamed to the filter pipeline with a valid/ready handshake.
// - One pixel per 32-bit word, bits [23:0]. Word address advances by 4 bytes per pixel.

---
 rtl/read_buffer_pkg.sv | 8 +
 rtl/read_buffer_counter.sv | 26 ++
 rtl/read_buffer.sv | 152 +++++++++++++++
 tb/tb_read_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_buffer_pkg.sv
// Shared types and constants for the read_buffer Avalon read master.
package read_buffer_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} rb_state_t;
   typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;

   localparam int unsigned PIXEL_W    = 24;
   localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/read_buffer_counter.sv
// flex_counter: counts 0..rollover_val-1; rollover_flag marks the increment that wraps.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);
   logic [NUM_CNT_BITS-1:0] count_inc;

   assign count_inc     = count_out + NUM_CNT_BITS'(1);
   assign rollover_flag = count_enable && (count_inc == rollover_val);

   always_ff @(posedge clk, negedge n_rst) begin
      if (!n_rst)
         count_out <= '0;
      else if (clear || rollover_flag)
         count_out <= '0;
      else if (count_enable)
         count_out <= count_inc;
   end
endmodule

// File: rtl/read_buffer.sv
// Avalon-MM read master fetching 24-bit pixels into ping-pong banks and
// streaming them out over a valid/ready handshake.
module read_buffer
   import read_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 6,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 20
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [CNT_W-1:0]   num_pixels,
   output logic [ADDR_W-1:0]  master_address,
   output logic               master_read,
   input  logic               master_waitrequest,
   input  logic [31:0]        master_readdata,
   input  logic               master_readdatavalid,
   output logic [PIXEL_W-1:0] pixel_data,
   output logic               pixel_valid,
   input  logic               pixel_ready,
   output logic               busy,
   output logic               done_read
);
   localparam int unsigned IW = $clog2(DEPTH + 1);

   rb_state_t          state, next_state;
   bank_state_t        bank_st [2];
   logic [IW-1:0]      blen [2];
   logic [PIXEL_W-1:0] mem [2][DEPTH];

   logic               fill_bank, ret_bank, drain_bank;
   logic [CNT_W-1:0]   num_q, issued, returned, consumed;
   logic [IW-1:0]      issue_idx, ret_idx, drain_idx, issue_len, ret_len;
   logic               job_start, accept, ret_ok, xfer;
   logic               issue_roll, ret_roll, drain_roll;
   logic               unused_readdata_hi;

   function automatic logic [IW-1:0] bank_len(input logic [CNT_W-1:0] remaining);
      return (remaining >= CNT_W'(DEPTH)) ? IW'(DEPTH) : remaining[IW-1:0];
   endfunction

   // Bank length is taken from the count remaining when the bank began,
   // so the in-bank index is added back to the running remainder.
   assign issue_len = bank_len(num_q - issued + CNT_W'(issue_idx));
   assign ret_len   = bank_len(num_q - returned + CNT_W'(ret_idx));

   assign job_start   = start && (state == IDLE);
   assign master_read = (state == ISSUE) && (bank_st[fill_bank] == BANK_EMPTY) && (issued != num_q);
   assign accept      = master_read && !master_waitrequest;
   assign ret_ok      = master_readdatavalid && (issued != returned);
   assign pixel_valid = (bank_st[drain_bank] == BANK_FULL);
   assign pixel_data  = pixel_valid ? mem[drain_bank][drain_idx] : '0;
   assign xfer        = pixel_valid && pixel_ready;
   assign busy        = (state != IDLE);
   assign done_read   = (state == FINISH);

   assign unused_readdata_hi = ^master_readdata[31:PIXEL_W];

   flex_counter #(.NUM_CNT_BITS(IW)) u_issue_cnt (
      .clk(clk), .n_rst(n_rst), .clear(job_start), .count_enable(accept),
      .rollover_val(issue_len), .count_out(issue_idx), .rollover_flag(issue_roll)
   );

   flex_counter #(.NUM_CNT_BITS(IW)) u_ret_cnt (
      .clk(clk), .n_rst(n_rst), .clear(job_start), .count_enable(ret_ok),
      .rollover_val(ret_len), .count_out(ret_idx), .rollover_flag(ret_roll)
   );

   flex_counter #(.NUM_CNT_BITS(IW)) u_drain_cnt (
      .clk(clk), .n_rst(n_rst), .clear(job_start), .count_enable(xfer),
      .rollover_val(blen[drain_bank]), .count_out(drain_idx), .rollover_flag(drain_roll)
   );

   always_ff @(posedge clk, negedge n_rst) begin
      if (!n_rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = (num_pixels == '0) ? FINISH : ISSUE;
         ISSUE:   if (issued == num_q) next_state = DRAIN;
         DRAIN:   if (consumed == num_q) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk, negedge n_rst) begin
      if (!n_rst) begin
         master_address <= '0;
         num_q          <= '0;
         issued         <= '0;
         returned       <= '0;
         consumed       <= '0;
         fill_bank      <= 1'b0;
         ret_bank       <= 1'b0;
         drain_bank     <= 1'b0;
         bank_st[0]     <= BANK_EMPTY;
         bank_st[1]     <= BANK_EMPTY;
         blen[0]        <= '0;
         blen[1]        <= '0;
      end else if (job_start) begin
         master_address <= base_addr;
         num_q          <= num_pixels;
         issued         <= '0;
         returned       <= '0;
         consumed       <= '0;
         fill_bank      <= 1'b0;
         ret_bank       <= 1'b0;
         drain_bank     <= 1'b0;
         bank_st[0]     <= BANK_EMPTY;
         bank_st[1]     <= BANK_EMPTY;
      end else begin
         if (accept) begin
            master_address <= master_address + ADDR_W'(WORD_BYTES);
            issued         <= issued + CNT_W'(1);
         end
         if (issue_roll) begin
            bank_st[fill_bank] <= BANK_FILLING;
            fill_bank          <= ~fill_bank;
         end
         if (ret_ok)
            returned <= returned + CNT_W'(1);
         if (ret_roll) begin
            bank_st[ret_bank] <= BANK_FULL;
            blen[ret_bank]    <= ret_len;
            ret_bank          <= ~ret_bank;
         end
         if (xfer)
            consumed <= consumed + CNT_W'(1);
         if (drain_roll) begin
            bank_st[drain_bank] <= BANK_EMPTY;
            drain_bank          <= ~drain_bank;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ret_ok)
         mem[ret_bank][ret_idx] <= master_readdata[PIXEL_W-1:0];
   end

   rdv_needs_outstanding: assert property (
      @(posedge clk) disable iff (!n_rst) master_readdatavalid |-> (issued != returned)
   );
endmodule

// File: tb/tb_read_buffer.sv
// Scoreboard bench for read_buffer: queued expected addresses/pixels checked by a monitor.
module tb_read_buffer;
   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [31:0] base_addr;
   logic [19:0] num_pixels;
   logic [31:0] master_address;
   logic        master_read;
   logic        master_waitrequest;
   logic [31:0] master_readdata;
   logic        master_readdatavalid;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        busy;
   logic        done_read;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_addr_q [$];
   logic [23:0] exp_pix_q [$];
   int          due_q [$];
   logic [31:0] radr_q [$];

   int          cyc = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;
   logic [31:0] last_acc = '0;
   int          stall_mode = 0;
   int          ready_mode = 1;
   int          lat = 1;

   read_buffer #(.DEPTH(6), .ADDR_W(32), .CNT_W(20)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
      .num_pixels(num_pixels), .master_address(master_address),
      .master_read(master_read), .master_waitrequest(master_waitrequest),
      .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .busy(busy), .done_read(done_read)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pix_of(input logic [31:0] a);
      return {8'h5A, a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory slave: waitrequest pattern, fixed read latency, ready pattern.
   initial begin
      master_waitrequest   = 1'b0;
      master_readdatavalid = 1'b0;
      master_readdata      = '0;
      pixel_ready          = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!n_rst) begin
            due_q.delete();
            radr_q.delete();
            master_waitrequest   = 1'b0;
            master_readdatavalid = 1'b0;
            pixel_ready          = 1'b0;
            continue;
         end
         master_waitrequest = (stall_mode != 0) ? ((cyc % 4) != 0) : 1'b0;
         case (ready_mode)
            0:       pixel_ready = 1'b0;
            1:       pixel_ready = 1'b1;
            default: pixel_ready = 1'($urandom_range(0, 1));
         endcase
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = {8'hEE, pix_of(radr_q[0])};
            void'(due_q.pop_front());
            void'(radr_q.pop_front());
         end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = 32'hDEAD_BEEF;
         end
         #1;
         if (master_read && !master_waitrequest) begin
            due_q.push_back(cyc + lat);
            radr_q.push_back(master_address);
            acc_cnt++;
            last_acc = master_address;
         end
      end
   end

   // Monitor: pops expectations on every accept / transfer / done pulse.
   initial begin
      logic        prev_stall = 1'b0;
      logic        prev_hold  = 1'b0;
      logic        prev_done  = 1'b0;
      logic [31:0] prev_addr  = '0;
      logic [23:0] prev_pix   = '0;
      logic [31:0] ea;
      logic [23:0] ep;
      forever begin
         @(negedge clk);
         #2;
         if (!n_rst) begin
            prev_stall = 1'b0;
            prev_hold  = 1'b0;
            prev_done  = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check("stall_read_held", 32'(master_read), 32'd1);
            check("stall_addr_held", master_address, prev_addr);
         end
         if (prev_hold) begin
            check("hold_valid_held", 32'(pixel_valid), 32'd1);
            check("hold_pixel_held", 32'(pixel_data), 32'(prev_pix));
         end
         if (master_read && !master_waitrequest) begin
            if (exp_addr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rd_extra: got read at %0h expected no read", master_address);
            end else begin
               ea = exp_addr_q.pop_front();
               check("rd_addr", master_address, ea);
            end
         end
         if (pixel_valid && pixel_ready) begin
            if (exp_pix_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL pix_extra: got pixel %0h expected no pixel", pixel_data);
            end else begin
               ep = exp_pix_q.pop_front();
               check("pix_data", 32'(pixel_data), 32'(ep));
            end
         end
         if (done_read) begin
            done_cnt++;
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("done_all_consumed", 32'(exp_pix_q.size()), 32'd0);
         end
         prev_stall = master_read && master_waitrequest;
         prev_addr  = master_address;
         prev_hold  = pixel_valid && !pixel_ready;
         prev_pix   = pixel_data;
         prev_done  = done_read;
      end
   end

   task automatic start_job(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(base + 32'(4 * i));
         exp_pix_q.push_back(pix_of(base + 32'(4 * i)));
      end
      @(negedge clk);
      base_addr  = base;
      num_pixels = 20'(n);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0);
      for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({name, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
      check({name, "_reads_left"}, 32'(exp_addr_q.size()), 32'd0);
      check({name, "_pixels_left"}, 32'(exp_pix_q.size()), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      int a0;
      n_rst      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      num_pixels = '0;
      #7;
      check("rst_read", 32'(master_read), 32'd0);
      check("rst_addr", master_address, 32'd0);
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_pixel", 32'(pixel_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done_read), 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // T1 basic
      d0 = done_cnt;
      start_job(32'h1000, 6);
      wait_done("t1", d0);
      check("t1_last_addr", last_acc, 32'h1014);

      // T2 ping-pong with consumer held off, plus a start while busy
      ready_mode = 0;
      d0 = done_cnt;
      a0 = acc_cnt;
      start_job(32'h8000, 12);
      @(negedge clk);
      base_addr  = 32'hF000;
      num_pixels = 20'd3;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && acc_cnt < a0 + 12; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      #2;
      check("t2_accepts", 32'(acc_cnt - a0), 32'd12);
      check("t2_read_dropped", 32'(master_read), 32'd0);
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_valid", 32'(pixel_valid), 32'd1);
      check("t2_head", 32'(pixel_data), 32'h5A8000);
      ready_mode = 1;
      wait_done("t2", d0);

      // T3 partial second bank
      d0 = done_cnt;
      start_job(32'h1000, 8);
      wait_done("t3", d0);
      check("t3_last_addr", last_acc, 32'h101C);

      // T4 stalls, long latency, random ready
      stall_mode = 1;
      lat        = 5;
      ready_mode = 2;
      d0 = done_cnt;
      start_job(32'h2000, 14);
      wait_done("t4", d0);
      check("t4_last_addr", last_acc, 32'h2034);
      stall_mode = 0;
      lat        = 1;
      ready_mode = 1;

      // T5 zero-length job
      d0 = done_cnt;
      a0 = acc_cnt;
      @(negedge clk);
      base_addr  = 32'h5000;
      num_pixels = '0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2;
      check("t5_done_next_cycle", 32'(done_read), 32'd1);
      check("t5_no_read", 32'(master_read), 32'd0);
      @(negedge clk);
      #2;
      check("t5_done_dropped", 32'(done_read), 32'd0);
      check("t5_idle", 32'(busy), 32'd0);
      check("t5_done_count", 32'(done_cnt), 32'(d0 + 1));
      check("t5_no_accepts", 32'(acc_cnt), 32'(a0));

      // T6 reset during ISSUE, then a fresh job
      d0 = done_cnt;
      a0 = acc_cnt;
      start_job(32'h3000, 12);
      for (int i = 0; i < 200 && acc_cnt < a0 + 3; i++) @(negedge clk);
      #3;
      n_rst = 1'b0;
      #1;
      check("t6_rst_read", 32'(master_read), 32'd0);
      check("t6_rst_addr", master_address, 32'd0);
      check("t6_rst_valid", 32'(pixel_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done_read), 32'd0);
      exp_addr_q.delete();
      exp_pix_q.delete();
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_no_done_after_abort", 32'(done_cnt), 32'(d0));
      check("t6_idle_after_reset", 32'(busy), 32'd0);
      d0 = done_cnt;
      start_job(32'h4000, 5);
      wait_done("t6", d0);
      check("t6_last_addr", last_acc, 32'h4010);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
